sync_fifo_cfg: RTL and testbench

Parametrised single-clock FIFO and the next generation of the team's basic synchronous FIFO. Adds a selectable read mode (standard registered read or first-word-fall-through), a fill-level count, programmable almost-full/almost-empty flags and optional sticky overflow/underflow error flags. Sits between producer and consumer logic in one clock domain wherever buffering with level-based flow control is needed.

---
 rtl/sync_fifo_pkg.sv | 16 +
 rtl/sync_fifo_ram.sv | 26 ++
 rtl/sync_fifo_cfg.sv | 143 ++++++++++++++
 tb/tb_sync_fifo_cfg.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for the configurable synchronous FIFO.
package sync_fifo_pkg;

    // Read-mode selector values for the FWFT parameter.
    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } read_mode_e;

    // Width of pointers and of the fill count: one extra bit so that
    // DEPTH itself is representable and the wrap bit separates full from empty.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array: one synchronous write port, one asynchronous read port.
module sync_fifo_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on an accepted push; no reset on storage.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_fifo_cfg.sv
// Configurable single-clock FIFO with standard or first-word-fall-through
// read mode, fill count, almost-full/almost-empty flags.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN
// is defined; otherwise they read as 0 and err_clr_i is ignored.
//
// Handshake: a push is accepted when push_i && !full_o, a pop when
// pop_i && !empty_o, both judged on the state before the clock edge.
// Rejected requests change nothing except the optional error flags.
module sync_fifo_cfg
    import sync_fifo_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          push_i,
    output logic                          full_o,
    input  logic [WIDTH-1:0]              data_i,
    input  logic                          pop_i,
    output logic                          empty_o,
    output logic [WIDTH-1:0]              data_o,
    output logic [cnt_width(DEPTH)-1:0]   count_o,
    output logic                          almost_full_o,
    output logic                          almost_empty_o,
    output logic                          overflow_o,
    output logic                          underflow_o,
    input  logic                          err_clr_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = cnt_width(DEPTH);

    logic [PW-1:0]    wr_ptr_q, rd_ptr_q, wr_ptr_n, rd_ptr_n, count_n;
    logic             full_q, empty_q, afull_q, aempty_q;
    logic [WIDTH-1:0] data_q, data_n, rd_data;
    logic [AW-1:0]    rd_addr;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    // Next pointers and fill level; pointers wrap modulo 2*DEPTH naturally.
    always_comb begin
        wr_ptr_n = wr_ptr_q + PW'(push_ok);
        rd_ptr_n = rd_ptr_q + PW'(pop_ok);
        count_n  = wr_ptr_n - rd_ptr_n;
    end

    // FWFT looks ahead at the post-edge head; standard mode reads the
    // entry being popped right now.
    always_comb begin
        rd_addr = rd_ptr_q[AW-1:0];
        if (FWFT == int'(FIFO_FWFT)) begin
            rd_addr = rd_ptr_n[AW-1:0];
        end
    end

    sync_fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (data_i),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // Output word selection. In FWFT mode, if the post-edge head is the word
    // being written on this same edge, bypass the array and take data_i.
    always_comb begin
        data_n = data_q;
        if (FWFT == int'(FIFO_FWFT)) begin
            if (count_n != '0) begin
                data_n = (rd_ptr_n == wr_ptr_q) ? data_i : rd_data;
            end
        end else if (pop_ok) begin
            data_n = rd_data;
        end
    end

    // Pointers, registered flags and output word.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_n;
            rd_ptr_q <= rd_ptr_n;
            full_q   <= (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]) &&
                        (wr_ptr_n[AW] != rd_ptr_n[AW]);
            empty_q  <= (wr_ptr_n == rd_ptr_n);
            afull_q  <= (count_n >= PW'(AFULL_THRESH));
            aempty_q <= (count_n <= PW'(AEMPTY_THRESH));
            data_q   <= data_n;
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign data_o         = data_q;

`ifdef SYNC_FIFO_ERR_EN
    logic ovf_q, unf_q;

    // Sticky error flags; a clear on the same edge beats a new event.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (err_clr_i) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (push_i && !push_ok) ovf_q <= 1'b1;
            if (pop_i && !pop_ok)   unf_q <= 1'b1;
        end
    end

    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_cfg.sv
// Bench for sync_fifo_cfg: a standard-mode and an FWFT-mode instance share
// one stimulus stream and are checked against a queue-based reference.
module tb_sync_fifo_cfg;

    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int AF_TH = DEPTH - 2;
    localparam int AE_TH = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          push = 1'b0, pop = 1'b0, clr = 1'b0;
    logic [W-1:0]  din = '0;

    logic          s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic [W-1:0]  s_data;
    logic [CW-1:0] s_count;
    logic          f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
    logic [W-1:0]  f_data;
    logic [CW-1:0] f_count;

    // Reference state
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  m_std, m_fwft;
    logic          m_ovf, m_unf;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    sync_fifo_cfg #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .full_o(s_full),
        .data_i(din), .pop_i(pop), .empty_o(s_empty), .data_o(s_data),
        .count_o(s_count), .almost_full_o(s_af), .almost_empty_o(s_ae),
        .overflow_o(s_ovf), .underflow_o(s_unf), .err_clr_i(clr)
    );

    sync_fifo_cfg #(.WIDTH(W), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk_i(clk), .rst_ni(rst_n), .push_i(push), .full_o(f_full),
        .data_i(din), .pop_i(pop), .empty_o(f_empty), .data_o(f_data),
        .count_o(f_count), .almost_full_o(f_af), .almost_empty_o(f_ae),
        .overflow_o(f_ovf), .underflow_o(f_unf), .err_clr_i(clr)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = exp_q.size();
        check("std.count",  W'(s_count), W'(sz));
        check("std.full",   W'(s_full),  W'(sz == DEPTH));
        check("std.empty",  W'(s_empty), W'(sz == 0));
        check("std.afull",  W'(s_af),    W'(sz >= AF_TH));
        check("std.aempty", W'(s_ae),    W'(sz <= AE_TH));
        check("std.ovf",    W'(s_ovf),   W'(m_ovf));
        check("std.unf",    W'(s_unf),   W'(m_unf));
        check("std.data",   s_data,      m_std);
        check("fwft.count", W'(f_count), W'(sz));
        check("fwft.full",  W'(f_full),  W'(sz == DEPTH));
        check("fwft.empty", W'(f_empty), W'(sz == 0));
        check("fwft.afull", W'(f_af),    W'(sz >= AF_TH));
        check("fwft.aempty",W'(f_ae),    W'(sz <= AE_TH));
        check("fwft.ovf",   W'(f_ovf),   W'(m_ovf));
        check("fwft.unf",   W'(f_unf),   W'(m_unf));
        check("fwft.data",  f_data,      m_fwft);
    endtask

    // ---------------- driver tasks ----------------
    // One clock cycle of stimulus; the reference advances on pre-edge state.
    task automatic step(input logic p, input logic q, input logic [W-1:0] d, input logic c);
        logic acc_push, acc_pop;
        push = p; pop = q; din = d; clr = c;
        acc_push = p && (exp_q.size() < DEPTH);
        acc_pop  = q && (exp_q.size() > 0);
        @(posedge clk); #1;
        if (acc_pop)  m_std = exp_q.pop_front();
        if (acc_push) exp_q.push_back(d);
`ifdef SYNC_FIFO_ERR_EN
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (p && !acc_push) m_ovf = 1'b1;
            if (q && !acc_pop)  m_unf = 1'b1;
        end
`endif
        if (exp_q.size() > 0) m_fwft = exp_q[0];
        check_all();
        push = 1'b0; pop = 1'b0; clr = 1'b0;
    endtask

    // Reset for one edge while requests are active.
    task automatic do_reset();
        rst_n = 1'b0; push = 1'b1; pop = 1'b1; din = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        exp_q.delete();
        m_std = '0; m_fwft = '0; m_ovf = 1'b0; m_unf = 1'b0;
        check_all();
        rst_n = 1'b1; push = 1'b0; pop = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_std = '0; m_fwft = '0; m_ovf = 1'b0; m_unf = 1'b0;
        do_reset();

        // Fill with 0x1..0x10, then one push too many
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, W'(i), 1'b0);
        step(1'b1, 1'b0, 32'h0000_0BAD, 1'b0);

        // Drain in order, then one pop too many
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);

        // Single word into an empty FIFO, then consume it
        step(1'b1, 1'b0, 32'h0000_00A5, 1'b0);
        step(1'b0, 1'b1, '0, 1'b0);

        // Push+pop while empty: push wins
        step(1'b1, 1'b1, 32'h1111_0000, 1'b0);
        for (int i = 1; i < DEPTH; i++) step(1'b1, 1'b0, 32'h1111_0000 + W'(i), 1'b0);
        // Push+pop while full: pop wins
        step(1'b1, 1'b1, 32'h2222_2222, 1'b0);

        // Drain to 5 and stream 40 cycles at constant level
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1, $urandom, 1'b0);

        // Build up to 9 entries, set overflow history stays, then reset mid-stream
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, $urandom, 1'b0);
        do_reset();

        // Error set then cleared in one cycle, clear beats a same-cycle event
        step(1'b0, 1'b1, '0, 1'b0);
        step(1'b0, 1'b1, '0, 1'b1);
        step(1'b1, 1'b0, 32'h3333_3333, 1'b0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50),
                 $urandom, ($urandom_range(0, 19) == 0));
        end

        // ---------------- report ----------------
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
